// File: rtl/acc_sched_pkg.sv
// rtl/acc_sched_pkg.sv - shared state encoding, job record and sizing for acc_sched
package acc_sched_pkg;

  localparam int DEF_LOG_MAX_ITERS          = 16;
  localparam int DEF_LOG_MAX_READS_PER_ITER = 16;
  localparam int DEF_LOG_JOB_SLOTS          = 2;
  localparam int DEF_JOB_ID_WIDTH           = 4;
  localparam int JOB_SLOTS                  = 1 << DEF_LOG_JOB_SLOTS;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CHECK  = 3'd1;
  localparam logic [2:0] ST_CONFIG = 3'd2;
  localparam logic [2:0] ST_RUN    = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  typedef struct packed {
    logic [DEF_JOB_ID_WIDTH-1:0]           id;
    logic [DEF_LOG_MAX_ITERS-1:0]          iters;
    logic [DEF_LOG_MAX_READS_PER_ITER-1:0] reads;
  } job_rec_t;

  // A zero count would leave ACC running forever or doing nothing; reject instead.
  function automatic logic is_bad_job(input job_rec_t j);
    return (j.iters == '0) || (j.reads == '0);
  endfunction

endpackage

// File: rtl/sched_job_fifo.sv
// rtl/sched_job_fifo.sv - job-record FIFO with registered count and full/empty flags
module sched_job_fifo #(
  parameter int DATA_W    = 36,
  parameter int LOG_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam logic [LOG_DEPTH:0] FULL_CNT = {1'b1, {LOG_DEPTH{1'b0}}};

  logic [DATA_W-1:0]    mem [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr;
  logic [LOG_DEPTH-1:0] rd_ptr;
  logic [LOG_DEPTH:0]   count;
  logic [LOG_DEPTH:0]   count_nxt;
  logic                 do_push;
  logic                 do_pop;

  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)
      count_nxt = count + 1'b1;
    else if (!do_push && do_pop)
      count_nxt = count - 1'b1;
  end

  // Flags come from the next count so they are registered yet current.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/acc_sched.sv
// rtl/acc_sched.sv - ACC job scheduler top; define ACC_SCHED_PERF_EN for run/stall counters
module acc_sched
  import acc_sched_pkg::*;
#(
  parameter int LOG_MAX_ITERS          = DEF_LOG_MAX_ITERS,
  parameter int LOG_MAX_READS_PER_ITER = DEF_LOG_MAX_READS_PER_ITER,
  parameter int LOG_JOB_SLOTS          = DEF_LOG_JOB_SLOTS,
  parameter int JOB_ID_WIDTH           = DEF_JOB_ID_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              job_valid,
  output logic                              job_ready,
  input  logic [LOG_MAX_ITERS-1:0]          job_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0] job_reads,
  input  logic [JOB_ID_WIDTH-1:0]           job_id,
  output logic                              acc_configure,
  output logic [LOG_MAX_ITERS-1:0]          acc_num_iters,
  output logic [LOG_MAX_READS_PER_ITER-1:0] acc_num_reads_per_iter,
  input  logic                              acc_valid_out,
  input  logic                              acc_avail_in,
  output logic                              busy,
  output logic                              job_done,
  output logic [JOB_ID_WIDTH-1:0]           job_done_id,
`ifdef ACC_SCHED_PERF_EN
  output logic [31:0]                       perf_run_cycles,
  output logic [31:0]                       perf_stall_cycles,
`endif
  output logic                              job_err
);

  logic [2:0]                        state;
  logic [2:0]                        state_nxt;
  job_rec_t                          push_rec;
  job_rec_t                          head;
  job_rec_t                          cur;
  logic                              fifo_full;
  logic                              fifo_empty;
  logic                              pop;
  logic                              beat;
  logic                              last_beat;
  logic                              bad;
  logic [LOG_MAX_READS_PER_ITER-1:0] beat_cnt;

  assign push_rec  = '{id: job_id, iters: job_iters, reads: job_reads};
  assign job_ready = ~fifo_full;
  assign pop       = (state == ST_IDLE) & ~fifo_empty;
  assign beat      = acc_valid_out & acc_avail_in;
  assign last_beat = beat && (beat_cnt == acc_num_reads_per_iter - 1'b1);
  assign bad       = is_bad_job(cur);

  sched_job_fifo #(
    .DATA_W    ($bits(job_rec_t)),
    .LOG_DEPTH (LOG_JOB_SLOTS)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (job_valid),
    .push_data (push_rec),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (!fifo_empty) state_nxt = ST_CHECK;
      ST_CHECK:  state_nxt = bad ? ST_IDLE : ST_CONFIG;
      ST_CONFIG: state_nxt = ST_RUN;
      ST_RUN:    if (last_beat) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so each pulse lines up with its state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state                  <= ST_IDLE;
      cur                    <= '0;
      beat_cnt               <= '0;
      acc_configure          <= 1'b0;
      acc_num_iters          <= '0;
      acc_num_reads_per_iter <= '0;
      busy                   <= 1'b0;
      job_done               <= 1'b0;
      job_done_id            <= '0;
      job_err                <= 1'b0;
    end else begin
      state         <= state_nxt;
      acc_configure <= (state_nxt == ST_CONFIG);
      busy          <= (state_nxt inside {ST_CONFIG, ST_RUN, ST_DONE});
      job_err       <= (state == ST_CHECK) && bad;
      job_done      <= ((state == ST_CHECK) && bad) || ((state == ST_RUN) && last_beat);
      if (pop) cur <= head;
      if (((state == ST_CHECK) && bad) || ((state == ST_RUN) && last_beat))
        job_done_id <= cur.id;
      if ((state == ST_CHECK) && !bad) begin
        acc_num_iters          <= cur.iters;
        acc_num_reads_per_iter <= cur.reads;
      end
      if (state == ST_CONFIG)
        beat_cnt <= '0;
      else if ((state == ST_RUN) && beat)
        beat_cnt <= beat_cnt + 1'b1;
    end
  end

`ifdef ACC_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_run_cycles   <= '0;
      perf_stall_cycles <= '0;
    end else if (state == ST_CONFIG) begin
      perf_run_cycles   <= '0;
      perf_stall_cycles <= '0;
    end else if (state == ST_RUN) begin
      perf_run_cycles <= perf_run_cycles + 32'd1;
      if (!acc_valid_out) perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule
